sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Time-multiplexed scan controller for a bank of seven-segment digits sharing one `sevenseg` BCD decoder. It holds a frame of BCD digits and drives one digit at a time: the current nibble goes to the decoder's `bcd_in`, and a one-hot digit enable goes to the display commons. A short blanking gap separates digits to prevent ghosting. New digit values are double-buffered and committed only at frame boundaries, so a displayed number never tears.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; must be ≥ 2.
- `REFRESH_DIV`, default 50000: clock cycles each digit is driven; must be ≥ 1.
- `BLANK_CYCLES`, default 16: clock cycles with all digits off between digits; must be ≥ 1.
- `clk` input, 1 bit: single clock; all state is on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `load` input, 1 bit: single-cycle strobe that captures `digits_in`.
- `digits_in` input, 4*NUM_DIGITS bits: BCD digits. Digit i is `[4i+3:4i]`; digit 0 is least significant.
- `lz_blank` input, 1 bit: enables leading-zero suppression.
- `bcd_out` output, 4 bits: nibble for the shared `sevenseg` decoder.
- `digit_en` output, NUM_DIGITS bits: one-hot, active-high digit common enable.
- `frame_done` output, 1 bit: one-cycle pulse when the scan wraps from the last digit to digit 0.

## Operation
- Registers:
  - `pending` and `pend_valid` hold a captured frame awaiting commit.
  - `display` holds the frame being shown.
  - `idx` is the current digit.
  - `cnt` is the phase counter.
  - `state` is one of {BLANK, DRIVE}.
- Reset values:
  - `state`=BLANK, `idx`=0, `cnt`=0.
  - `pending`, `display` and `pend_valid` all 0.
  - Outputs: `bcd_out`=0, `digit_en`=0, `frame_done`=0.
- Load: when `load`=1, `pending`<=`digits_in` and `pend_valid`<=1. Repeated loads before a commit overwrite `pending`; the last one wins.
- Commit: happens on the BLANK->DRIVE transition while `idx`=0, if `pend_valid`=1. It sets `display`<=`pending` and `pend_valid`<=0.
- Simultaneous `load` and commit in one cycle: `display` takes the old `pending`. `pending` takes the new `digits_in`, and `pend_valid` stays 1.
- BLANK state:
  - `digit_en`=0; `bcd_out`=`display[idx]`.
  - `cnt` counts 0..BLANK_CYCLES-1.
  - At terminal count: `cnt`<=0, go to DRIVE.
- DRIVE state:
  - `digit_en`=one-hot(`idx`) unless digit `idx` is suppressed; `bcd_out`=`display[idx]`.
  - `cnt` counts 0..REFRESH_DIV-1.
  - At terminal count: `cnt`<=0, go to BLANK, and `idx`<=`idx`+1, wrapping NUM_DIGITS-1->0.
  - On that wrap, `frame_done`=1 for one cycle.
- Leading-zero suppression: with `lz_blank`=1, digit i>0 is suppressed when it and every higher digit of `display` equal 0. Digit 0 is never suppressed. A suppressed digit keeps `digit_en`=0 throughout its DRIVE slot; slot timing is unchanged.
- Nibbles greater than 9 pass through unchanged with the digit enabled. The decoder blanks them.
- `lz_blank` is sampled combinationally against `display` each cycle and may change at any time.

## Timing
- All outputs are registered; they reflect `state`/`idx` with one cycle of latency from internal decisions.
- After `reset_n` deasserts, BLANK runs for BLANK_CYCLES cycles. `digit_en`=0b0001 is first seen on the following cycle and stays for exactly REFRESH_DIV cycles.
- Frame period is NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
- `load` to visible latency is at most one frame period plus BLANK_CYCLES.
- `bcd_out` settles during BLANK, before `digit_en` rises. `digit_en` is never active in two consecutive digit slots without at least BLANK_CYCLES of zeros between them.
- Reset asserted mid-frame: all registers, including `pending`, return to reset values immediately (asynchronously). An uncommitted load is discarded.

## Test plan
Common parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2.

- Reset then idle: `digit_en` sequence is 0 (2 cycles), 0001 (4), 0 (2), 0010 (4), … 1000 (4). `frame_done` pulses once every 24 cycles. `bcd_out`=0 throughout.
- `load` with `digits_in`=0x1234 mid-frame: `display` unchanged until the next frame start. From then on, `bcd_out`=4,3,2,1 across digits 0..3.
- Two loads, 0x1111 then 0x5678, within one frame: only 0x5678 is displayed. 0x1111 never appears.
- `load` of 0x9999 exactly on the commit cycle, with 0x1234 pending: this frame shows 0x1234. The next frame shows 0x9999.
- `lz_blank`=1 with `display`=0x0070: `digit_en` is active only in the slots for digits 0 and 1. 0x0000 shows only digit 0.
- `reset_n` pulsed low in a DRIVE slot of digit 2 with a load pending: outputs are immediately 0. After reset, the display shows 0x0000 and the scan restarts at digit 0.

Source files
------------

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed scan controller for a bank of seven-segment
// digits sharing one BCD decoder. New frames are double-buffered and only
// committed at the start of a frame so a displayed number never tears.
module sevenseg_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    lz_blank,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    commit;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend_valid;
    logic [4*NUM_DIGITS-1:0] display;
    logic [4*NUM_DIGITS-1:0] display_nxt;

    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [NUM_DIGITS-1:0]   suppress;
    logic [NUM_DIGITS-1:0]   en_nxt;
    logic [3:0]              bcd_nxt;

    // Phase sequencing: count through the blank gap, then the drive slot,
    // advancing to the next digit at the end of each drive slot.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        commit    = 1'b0;
        wrap      = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = DRIVE;
                    commit    = (idx == '0) && pend_valid;
                end
            end
            DRIVE: begin
                if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = BLANK;
                    if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                        idx_nxt = '0;
                        wrap    = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Double buffer: a load always lands in pending, and a commit moves the
    // previous pending into display; a load in the commit cycle stays pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= '0;
            pend_valid <= 1'b0;
            display    <= '0;
        end else begin
            if (commit) begin
                display    <= pending;
                pend_valid <= 1'b0;
            end
            if (load) begin
                pending    <= digits_in;
                pend_valid <= 1'b1;
            end
        end
    end

    // Leading-zero suppression: a digit is blank when it and every higher digit
    // are zero; digit 0 always stays lit so a zero value still shows "0".
    always_comb begin
        upper_zero = '0;
        suppress   = '0;
        upper_zero[NUM_DIGITS-1] = (display[4*(NUM_DIGITS-1) +: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (display[4*i +: 4] == 4'd0);
        end
        for (int i = 1; i < NUM_DIGITS; i++) begin
            suppress[i] = lz_blank && upper_zero[i];
        end
    end

    // Output selection. The nibble is taken from the frame about to be shown,
    // so on a commit the decoder input changes while the commons are still off.
    always_comb begin
        display_nxt = commit ? pending : display;
        bcd_nxt     = 4'd0;
        en_nxt      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                bcd_nxt   = display_nxt[4*i +: 4];
                en_nxt[i] = (state == DRIVE) && !suppress[i];
            end
        end
    end

    // Registered outputs, one cycle behind the scan state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_out    <= 4'd0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            bcd_out    <= bcd_nxt;
            digit_en   <= en_nxt;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: scoreboard bench for sevenseg_scan. A timeline model
// derived from the cycle count since reset predicts each registered output.
module tb_sevenseg_scan;

    localparam int N    = 4;
    localparam int R    = 4;
    localparam int B    = 2;
    localparam int SLOT = R + B;
    localparam int P    = N * SLOT;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           load;
    logic [4*N-1:0] digits_in;
    logic           lz_blank;
    logic [3:0]     bcd_out;
    logic [N-1:0]   digit_en;
    logic           frame_done;

    typedef struct {
        logic [N-1:0] en;
        logic [3:0]   bcd;
        logic         fd;
    } exp_t;

    exp_t exp_q[$];

    int check_count = 0;
    int error_count = 0;

    int             mc        = 0;
    logic [4*N-1:0] m_pending = '0;
    logic           m_valid   = 1'b0;
    logic [4*N-1:0] m_disp    = '0;

    sevenseg_scan #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .digits_in (digits_in),
        .lz_blank  (lz_blank),
        .bcd_out   (bcd_out),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [3:0] digit_of(input logic [4*N-1:0] d, input int s);
        logic [4*N-1:0] t;
        t = d >> (4 * s);
        return t[3:0];
    endfunction

    function automatic logic is_suppressed(input logic [4*N-1:0] d, input int s, input logic lz);
        if (!lz || s == 0) return 1'b0;
        return (d >> (4 * s)) == '0;
    endfunction

    // Reference model: the scan position follows purely from cycles since reset.
    always @(posedge clk) begin
        int             pos;
        int             slot;
        logic           drive;
        logic           commit;
        logic [4*N-1:0] new_disp;
        exp_t           e;
        if (!reset_n) begin
            mc        = 0;
            m_pending = '0;
            m_valid   = 1'b0;
            m_disp    = '0;
            exp_q.delete();
        end else begin
            pos      = mc % P;
            slot     = pos / SLOT;
            drive    = (pos % SLOT) >= B;
            commit   = (pos == B - 1) && m_valid;
            new_disp = commit ? m_pending : m_disp;
            e.en     = (drive && !is_suppressed(m_disp, slot, lz_blank)) ? N'(1 << slot) : '0;
            e.bcd    = digit_of(new_disp, slot);
            e.fd     = (pos == P - 1);
            exp_q.push_back(e);
            m_disp = new_disp;
            if (commit) m_valid = 1'b0;
            if (load) begin
                m_pending = digits_in;
                m_valid   = 1'b1;
            end
            mc++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic next_cycle();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("digit_en", 32'(digit_en), 32'(e.en));
            checkOutput("bcd_out", 32'(bcd_out), 32'(e.bcd));
            checkOutput("frame_done", 32'(frame_done), 32'(e.fd));
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic wait_pos(input int p);
        int guard = 0;
        while ((mc % P) != p && guard < 2 * P) begin
            next_cycle();
            guard++;
        end
        checkOutput("wait_pos", 32'(mc % P), 32'(p));
    endtask

    task automatic applyStimulus(input logic [4*N-1:0] value);
        digits_in = value;
        load      = 1'b1;
        next_cycle();
        load      = 1'b0;
        digits_in = '1;
    endtask

    // Main sequence of directed scenarios.
    initial begin
        reset_n   = 1'b0;
        load      = 1'b0;
        digits_in = '1;
        lz_blank  = 1'b0;

        next_cycle();
        checkOutput("reset_en", 32'(digit_en), 32'h0);
        checkOutput("reset_bcd", 32'(bcd_out), 32'h0);
        checkOutput("reset_fd", 32'(frame_done), 32'h0);
        next_cycle();
        reset_n = 1'b1;

        run_cycles(50);

        wait_pos(10);
        applyStimulus(16'h1234);
        run_cycles(60);

        wait_pos(5);
        applyStimulus(16'h1111);
        wait_pos(10);
        applyStimulus(16'h5678);
        run_cycles(60);

        wait_pos(10);
        applyStimulus(16'h1234);
        wait_pos(1);
        applyStimulus(16'h9999);
        run_cycles(60);

        lz_blank = 1'b1;
        wait_pos(10);
        applyStimulus(16'h0070);
        run_cycles(50);
        wait_pos(10);
        applyStimulus(16'h0000);
        run_cycles(50);
        wait_pos(14);
        lz_blank = 1'b0;
        run_cycles(30);

        wait_pos(10);
        applyStimulus(16'h4321);
        run_cycles(30);
        wait_pos(5);
        applyStimulus(16'h8888);
        wait_pos(15);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_en", 32'(digit_en), 32'h0);
        checkOutput("midreset_bcd", 32'(bcd_out), 32'h0);
        checkOutput("midreset_fd", 32'(frame_done), 32'h0);
        run_cycles(2);
        reset_n = 1'b1;
        run_cycles(60);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
